// File: rtl/uvme_sb_st_stream_dut.sv
// Purpose: in-order abc->def stream stage with age-gated FIFO; optional def_data bit-0 corruption.
// Latency: LATENCY cycles minimum from abc acceptance to def_valid; 1 beat/cycle sustained.
// Backpressure: abc_ready drops only when all DEPTH entries are held; def beats hold stable until def_ready.
// Ports: clk/reset (sync, active-high); abc_* input stream; def_* output stream;
//        occupancy/in_count/out_count status; err_inj_en/err_inj_idx select the beat to corrupt.
// Optional feature macro: UVME_SB_ST_STREAM_DUT_ERR_INJ_EN (undefined: injection ports ignored).
module uvme_sb_st_stream_dut #(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 8,
    parameter int LATENCY = 4,
    parameter int CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     abc_valid,
    output logic                     abc_ready,
    input  logic [DATA_W-1:0]        abc_data,
    output logic                     def_valid,
    input  logic                     def_ready,
    output logic [DATA_W-1:0]        def_data,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic [CNT_W-1:0]         in_count,
    output logic [CNT_W-1:0]         out_count,
    input  logic                     err_inj_en,
    input  logic [CNT_W-1:0]         err_inj_idx
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam int AGE_W = $clog2(LATENCY + 1);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
    localparam logic [AGE_W-1:0] AGE_MAX  = AGE_W'(LATENCY);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [AGE_W-1:0]  age_q [DEPTH];
    logic [AGE_W-1:0]  age_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic [CNT_W-1:0]  in_cnt_q, in_cnt_d;
    logic [CNT_W-1:0]  out_cnt_q, out_cnt_d;

    logic              push;
    logic              pop;
    logic [DATA_W-1:0] head_dat;

    // reset gates the handshakes directly so both sides are idle for the
    // whole reset cycle and input is accepted in the first cycle after it.
    assign abc_ready = !reset && (occ_q != OCC_FULL);
    assign def_valid = !reset && (occ_q != '0) && (age_q[rd_ptr_q] == AGE_MAX);
    assign push      = abc_valid && abc_ready;
    assign pop       = def_valid && def_ready;
    assign head_dat  = mem_q[rd_ptr_q];

    assign occupancy = occ_q;
    assign in_count  = in_cnt_q;
    assign out_count = out_cnt_q;

`ifdef UVME_SB_ST_STREAM_DUT_ERR_INJ_EN
    // Corruption is applied on the output path only; the stored entry keeps
    // its true value. out_count is stable until the pop, so the flipped beat
    // stays flipped until it is consumed.
    logic inj_hit;
    assign inj_hit  = err_inj_en && (out_cnt_q == err_inj_idx);
    assign def_data = def_valid ? (head_dat ^ DATA_W'(inj_hit)) : '0;
`else
    logic unused_err_inj;
    assign unused_err_inj = ^{err_inj_en, err_inj_idx};
    assign def_data       = def_valid ? head_dat : '0;
`endif

    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        occ_d     = occ_q;
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;

        // Every slot ages each cycle; stale slots are harmless because a
        // push restarts the age of the slot it writes.
        for (int i = 0; i < DEPTH; i++) begin
            age_d[i] = (age_q[i] == AGE_MAX) ? age_q[i] : age_q[i] + AGE_W'(1);
        end

        if (push) begin
            mem_d[wr_ptr_q] = abc_data;
            age_d[wr_ptr_q] = AGE_W'(1);
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            in_cnt_d        = in_cnt_q + CNT_W'(1);
        end

        if (pop) begin
            rd_ptr_d  = rd_ptr_q + PTR_W'(1);
            out_cnt_d = out_cnt_q + CNT_W'(1);
        end

        case ({push, pop})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            occ_q     <= '0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                age_q[i] <= '0;
            end
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            occ_q     <= occ_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            age_q     <= age_d;
        end
    end

    // Payload storage carries no reset; validity comes from occupancy/age.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_uvme_sb_st_stream_dut.sv
module tb_uvme_sb_st_stream_dut;

    localparam int DATA_W  = 32;
    localparam int DEPTH   = 8;
    localparam int LATENCY = 4;
    localparam int CNT_W   = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              abc_valid;
    logic              abc_ready;
    logic [DATA_W-1:0] abc_data;
    logic              def_valid;
    logic              def_ready;
    logic [DATA_W-1:0] def_data;
    logic [3:0]        occupancy;
    logic [CNT_W-1:0]  in_count;
    logic [CNT_W-1:0]  out_count;
    logic              err_inj_en;
    logic [CNT_W-1:0]  err_inj_idx;

    uvme_sb_st_stream_dut #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .LATENCY(LATENCY),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .abc_valid  (abc_valid),
        .abc_ready  (abc_ready),
        .abc_data   (abc_data),
        .def_valid  (def_valid),
        .def_ready  (def_ready),
        .def_data   (def_data),
        .occupancy  (occupancy),
        .in_count   (in_count),
        .out_count  (out_count),
        .err_inj_en (err_inj_en),
        .err_inj_idx(err_inj_idx)
    );

    always #5 clk = ~clk;

    int                tests_run;
    int                fails;
    logic [DATA_W-1:0] sb_q [$];
    logic [DATA_W-1:0] obs_q [$];
    logic [CNT_W-1:0]  tb_pushes;
    logic [CNT_W-1:0]  tb_pops;
    logic              prev_stall;
    logic [DATA_W-1:0] prev_data;
    logic              bp_done;

    // Scoreboard/monitor: samples at the falling edge, pushes accepted abc
    // beats, pops and compares def beats, checks stall stability and counters.
    task automatic monitor();
        logic [DATA_W-1:0] exp;
        forever begin
            @(negedge clk);
            if (reset) begin
                sb_q.delete();
                tb_pushes  = '0;
                tb_pops    = '0;
                prev_stall = 1'b0;
            end else begin
                tests_run++;
                if (in_count !== tb_pushes || out_count !== tb_pops) begin
                    fails++;
                    $display("FAIL counters: in_count=%0d out_count=%0d, want %0d/%0d",
                             in_count, out_count, tb_pushes, tb_pops);
                end
                if (prev_stall) begin
                    tests_run++;
                    if (def_valid !== 1'b1 || def_data !== prev_data) begin
                        fails++;
                        $display("FAIL stall_stable: valid=%b data=%h, want valid=1 data=%h",
                                 def_valid, def_data, prev_data);
                    end
                end
                prev_stall = def_valid && !def_ready;
                prev_data  = def_data;
                if (abc_valid && abc_ready) begin
                    sb_q.push_back(abc_data);
                    tb_pushes++;
                end
                if (def_valid && def_ready) begin
                    tests_run++;
                    if (sb_q.size() == 0) begin
                        fails++;
                        $display("FAIL unexpected_beat: got %h, want no beat", def_data);
                    end else begin
                        exp = sb_q.pop_front();
`ifdef UVME_SB_ST_STREAM_DUT_ERR_INJ_EN
                        if (err_inj_en && tb_pops == err_inj_idx) exp[0] = ~exp[0];
`endif
                        if (def_data !== exp) begin
                            fails++;
                            $display("FAIL order_data: got %h, want %h", def_data, exp);
                        end
                    end
                    obs_q.push_back(def_data);
                    tb_pops++;
                end
            end
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset     = 1'b1;
        abc_valid = 1'b0;
        @(posedge clk); #1;
        reset     = 1'b0;
    endtask

    // Holds abc_valid/abc_data until accepted; returns 1 ns after that edge.
    task automatic send(input logic [DATA_W-1:0] d);
        abc_valid = 1'b1;
        abc_data  = d;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (abc_ready) begin
                @(posedge clk); #1;
                return;
            end
        end
        tests_run++;
        fails++;
        $display("FAIL send_timeout: beat %h never accepted, want acceptance", d);
    endtask

    task automatic drain();
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (sb_q.size() == 0 && occupancy == 4'd0) begin
                tests_run++;
                return;
            end
        end
        tests_run++;
        fails++;
        $display("FAIL drain_timeout: %0d beats left, occupancy=%0d, want 0", sb_q.size(), occupancy);
    endtask

    task automatic test_reset();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (abc_ready !== 1'b0) begin fails++; $display("FAIL rst_abc_ready: got %b want 0", abc_ready); end
        tests_run++;
        if (def_valid !== 1'b0) begin fails++; $display("FAIL rst_def_valid: got %b want 0", def_valid); end
        tests_run++;
        if (def_data !== '0) begin fails++; $display("FAIL rst_def_data: got %h want 0", def_data); end
        tests_run++;
        if (occupancy !== 4'd0) begin fails++; $display("FAIL rst_occupancy: got %0d want 0", occupancy); end
        tests_run++;
        if (in_count !== '0 || out_count !== '0) begin
            fails++; $display("FAIL rst_counts: got %0d/%0d want 0/0", in_count, out_count);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        tests_run++;
        if (abc_ready !== 1'b1) begin fails++; $display("FAIL post_rst_abc_ready: got %b want 1", abc_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_latency();
        do_reset();
        def_ready = 1'b1;
        repeat (6) begin @(posedge clk); #1; end
        abc_valid = 1'b1;
        abc_data  = 32'hDEAD_BEEF;
        @(negedge clk);
        tests_run++;
        if (abc_ready !== 1'b1) begin fails++; $display("FAIL lat_ready: got %b want 1", abc_ready); end
        @(posedge clk); #1;
        abc_valid = 1'b0;
        for (int k = 1; k <= LATENCY + 2; k++) begin
            @(negedge clk);
            tests_run++;
            if (def_valid !== (k == LATENCY)) begin
                fails++; $display("FAIL lat_valid_T+%0d: got %b want %b", k, def_valid, (k == LATENCY));
            end
            if (k == LATENCY) begin
                tests_run++;
                if (def_data !== 32'hDEAD_BEEF) begin
                    fails++; $display("FAIL lat_data: got %h want deadbeef", def_data);
                end
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        tests_run++;
        if (in_count !== 16'd1 || out_count !== 16'd1) begin
            fails++; $display("FAIL lat_counts: got %0d/%0d want 1/1", in_count, out_count);
        end
    endtask

    task automatic test_fill_full();
        do_reset();
        def_ready = 1'b0;
        for (int i = 1; i <= DEPTH; i++) send(DATA_W'(i));
        abc_valid = 1'b1;
        abc_data  = 32'd9;
        @(negedge clk);
        tests_run++;
        if (abc_ready !== 1'b0) begin fails++; $display("FAIL full_ready: got %b want 0", abc_ready); end
        tests_run++;
        if (occupancy !== 4'd8) begin fails++; $display("FAIL full_occ: got %0d want 8", occupancy); end
        repeat (3) begin @(posedge clk); #1; end
        @(negedge clk);
        tests_run++;
        if (in_count !== 16'd8) begin fails++; $display("FAIL full_hold: in_count %0d want 8", in_count); end
        @(posedge clk); #1;
        def_ready = 1'b1;
        @(negedge clk);
        tests_run++;
        if (abc_ready !== 1'b0 || def_valid !== 1'b1) begin
            fails++; $display("FAIL first_pop: ready=%b valid=%b want 0/1", abc_ready, def_valid);
        end
        @(posedge clk); #1;
        @(negedge clk);
        tests_run++;
        if (abc_ready !== 1'b1) begin fails++; $display("FAIL ninth_accept: ready=%b want 1", abc_ready); end
        @(posedge clk); #1;
        abc_valid = 1'b0;
        drain();
        tests_run++;
        if (out_count !== 16'd9) begin fails++; $display("FAIL full_out: got %0d want 9", out_count); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        def_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            abc_valid = 1'b1;
            abc_data  = 32'h0000_1000 + DATA_W'(i);
            @(negedge clk);
            if (i >= LATENCY) begin
                tests_run++;
                if (occupancy !== 4'd4 || def_valid !== 1'b1 || abc_ready !== 1'b1) begin
                    fails++;
                    $display("FAIL stream_%0d: occ=%0d valid=%b ready=%b want 4/1/1",
                             i, occupancy, def_valid, abc_ready);
                end
            end
            @(posedge clk); #1;
        end
        abc_valid = 1'b0;
        for (int k = 0; k < LATENCY; k++) begin
            @(negedge clk);
            tests_run++;
            if (def_valid !== 1'b1) begin fails++; $display("FAIL stream_tail_%0d: valid=%b want 1", k, def_valid); end
            @(posedge clk); #1;
        end
        drain();
        tests_run++;
        if (in_count !== 16'd100 || out_count !== 16'd100) begin
            fails++; $display("FAIL stream_counts: got %0d/%0d want 100/100", in_count, out_count);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        bp_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) send(32'h0000_A000 + DATA_W'(i));
                abc_valid = 1'b0;
                bp_done   = 1'b1;
            end
            begin
                while (!bp_done) begin
                    def_ready = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                end
                def_ready = 1'b1;
            end
        join
        drain();
        tests_run++;
        if (out_count !== 16'd40) begin fails++; $display("FAIL bp_out: got %0d want 40", out_count); end
    endtask

    task automatic test_mid_reset();
        int seen;
        do_reset();
        def_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(32'h0000_5000 + DATA_W'(i));
        abc_valid = 1'b0;
        @(negedge clk);
        tests_run++;
        if (occupancy !== 4'd5) begin fails++; $display("FAIL mid_occ: got %0d want 5", occupancy); end
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        tests_run++;
        if (def_valid !== 1'b0 || occupancy !== 4'd0) begin
            fails++; $display("FAIL mid_clear: valid=%b occ=%0d want 0/0", def_valid, occupancy);
        end
        tests_run++;
        if (in_count !== '0 || out_count !== '0) begin
            fails++; $display("FAIL mid_counts: got %0d/%0d want 0/0", in_count, out_count);
        end
        @(posedge clk); #1;
        def_ready = 1'b1;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (def_valid) seen++;
        end
        tests_run++;
        if (seen != 0) begin fails++; $display("FAIL mid_no_emit: %0d beats seen want 0", seen); end
        @(posedge clk); #1;
    endtask

    task automatic test_err_inj();
        logic [DATA_W-1:0] want4;
        do_reset();
        obs_q.delete();
        def_ready   = 1'b1;
        err_inj_en  = 1'b1;
        err_inj_idx = 16'd3;
        for (int i = 0; i < 6; i++) send(32'h10 + DATA_W'(i));
        abc_valid = 1'b0;
        drain();
        err_inj_en = 1'b0;
`ifdef UVME_SB_ST_STREAM_DUT_ERR_INJ_EN
        want4 = 32'h12;
`else
        want4 = 32'h13;
`endif
        tests_run++;
        if (obs_q.size() != 6) begin
            fails++; $display("FAIL inj_count: got %0d beats want 6", obs_q.size());
        end else begin
            tests_run++;
            if (obs_q[3] !== want4) begin fails++; $display("FAIL inj_beat4: got %h want %h", obs_q[3], want4); end
            tests_run++;
            if (obs_q[2] !== 32'h12 || obs_q[4] !== 32'h14) begin
                fails++; $display("FAIL inj_neighbours: got %h/%h want 12/14", obs_q[2], obs_q[4]);
            end
        end
    endtask

    initial begin
        tests_run   = 0;
        fails       = 0;
        tb_pushes   = '0;
        tb_pops     = '0;
        prev_stall  = 1'b0;
        prev_data   = '0;
        bp_done     = 1'b0;
        reset       = 1'b1;
        abc_valid   = 1'b0;
        abc_data    = '0;
        def_ready   = 1'b0;
        err_inj_en  = 1'b0;
        err_inj_idx = '0;
        fork
            monitor();
        join_none
        test_reset();
        test_latency();
        test_fill_full();
        test_back_to_back();
        test_backpressure();
        test_mid_reset();
        test_err_inj();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
